// File: rtl/bus_snoop_controller_pkg.sv
// Shared types for the LLC bus snoop controller: bus operation and snoop
// result encodings, controller state, and the snoop priority merge.
package bus_snoop_controller_pkg;

    typedef enum logic [1:0] {
        BUS_READ       = 2'd0,
        BUS_WRITE      = 2'd1,
        BUS_INVALIDATE = 2'd2,
        BUS_RWIM       = 2'd3
    } bus_op_t;

    typedef enum logic [1:0] {
        SNOOP_NOHIT = 2'd0,
        SNOOP_HIT   = 2'd1,
        SNOOP_HITM  = 2'd2
    } snoop_result_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SNOOP,
        ST_COLLECT,
        ST_FLUSH_WAIT,
        ST_MEM,
        ST_DONE
    } ctrl_state_t;

    // Priority HITM > HIT > NOHIT; the unused encoding 2'd3 ranks as NOHIT.
    function automatic snoop_result_t snoop_merge(input snoop_result_t a, input snoop_result_t b);
        if (a == SNOOP_HITM || b == SNOOP_HITM) begin
            return SNOOP_HITM;
        end
        if (a == SNOOP_HIT || b == SNOOP_HIT) begin
            return SNOOP_HIT;
        end
        return SNOOP_NOHIT;
    endfunction

endpackage

// File: rtl/bus_snoop_controller_if.sv
// Bus-side signal bundle of the snoop controller. The slave modport is the
// controller's view; the master modport is the LLC/memory side.
interface bus_snoop_controller_if
    import bus_snoop_controller_pkg::*;
#(
    parameter int ADDRESS_SIZE = 32,
    parameter int NUM_CACHES   = 4,
    parameter int COUNTER_SIZE = 32
);
    localparam int ID_W = (NUM_CACHES > 1) ? $clog2(NUM_CACHES) : 1;

    logic                      req_valid;
    logic                      req_ready;
    bus_op_t                   req_op;
    logic [ADDRESS_SIZE-1:0]   req_addr;
    logic [ID_W-1:0]           req_id;

    logic [NUM_CACHES-1:0]     snoop_valid;
    bus_op_t                   snoop_op;
    logic [ADDRESS_SIZE-1:0]   snoop_addr;
    logic [NUM_CACHES-1:0]     snoop_resp_valid;
    logic [2*NUM_CACHES-1:0]   snoop_resp;
    logic                      flush_valid;

    logic                      mem_req_valid;
    logic                      mem_req_write;
    logic [ADDRESS_SIZE-1:0]   mem_req_addr;
    logic                      mem_ack;

    logic                      resp_valid;
    snoop_result_t             resp_result;
    logic                      resp_error;
    logic [COUNTER_SIZE-1:0]   txn_count;

    modport slave (
        input  req_valid, req_op, req_addr, req_id,
        input  snoop_resp_valid, snoop_resp, flush_valid, mem_ack,
        output req_ready, snoop_valid, snoop_op, snoop_addr,
        output mem_req_valid, mem_req_write, mem_req_addr,
        output resp_valid, resp_result, resp_error, txn_count
    );

    modport master (
        output req_valid, req_op, req_addr, req_id,
        output snoop_resp_valid, snoop_resp, flush_valid, mem_ack,
        input  req_ready, snoop_valid, snoop_op, snoop_addr,
        input  mem_req_valid, mem_req_write, mem_req_addr,
        input  resp_valid, resp_result, resp_error, txn_count
    );

endinterface

// File: rtl/bus_snoop_controller_snoop_collector.sv
// Snoop response collector: tracks which snoopers still owe a response,
// merges their results, flags multiple HITM owners and times out silent
// snoopers or a missing flush.
module snoop_collector
    import bus_snoop_controller_pkg::*;
#(
    parameter int NUM_CACHES    = 4,
    parameter int SNOOP_TIMEOUT = 15
)
(
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    i_start,
    input  logic [NUM_CACHES-1:0]   i_target,
    input  logic                    i_collect,
    input  logic                    i_flush_wait,
    input  logic [NUM_CACHES-1:0]   i_resp_valid,
    input  logic [2*NUM_CACHES-1:0] i_resp,
    output logic                    o_done,
    output logic                    o_timeout,
    output snoop_result_t           o_result,
    output logic                    o_error
);
    localparam int TIMER_W = $clog2(SNOOP_TIMEOUT + 1);
    localparam logic [TIMER_W-1:0] TIMER_LIMIT = TIMER_W'(SNOOP_TIMEOUT);

    logic [NUM_CACHES-1:0] r_pending;
    snoop_result_t         r_result;
    logic                  r_error;
    logic                  r_hitm_seen;
    logic [TIMER_W-1:0]    r_timer;

    logic [NUM_CACHES-1:0] w_accept;
    logic [NUM_CACHES-1:0] w_pending_next;
    snoop_result_t         w_merged;
    logic                  w_any_hitm;
    logic                  w_multi_hitm;
    logic                  w_error_next;

    // Merge this cycle's responses from still-pending snoopers into the running result.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        w_accept     = '0;
        w_merged     = r_result;
        w_any_hitm   = r_hitm_seen;
        w_multi_hitm = 1'b0;
        if (i_collect) begin
            w_accept = i_resp_valid & r_pending;
            for (int i = 0; i < NUM_CACHES; i++) begin
                if (w_accept[i]) begin
                    w_merged = snoop_merge(w_merged, snoop_result_t'(i_resp[2*i +: 2]));
                    if (i_resp[2*i +: 2] == SNOOP_HITM) begin
                        if (w_any_hitm) begin
                            w_multi_hitm = 1'b1;
                        end
                        w_any_hitm = 1'b1;
                    end
                end
            end
        end
        w_pending_next = r_pending & ~w_accept;
        o_timeout      = (r_timer == TIMER_LIMIT);
        o_done         = i_collect && ((w_pending_next == '0) || o_timeout);
        w_error_next   = r_error | w_multi_hitm | (o_timeout && (w_pending_next != '0));
    end

    assign o_result = w_merged;
    assign o_error  = r_error;

    // Load the target mask at snoop time, then retire responses and run the timer.
    always_ff @(posedge clock or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset) begin
            r_pending   <= '0;
            r_result    <= SNOOP_NOHIT;
            r_error     <= 1'b0;
            r_hitm_seen <= 1'b0;
            r_timer     <= '0;
        end else if (i_start) begin
            r_pending   <= i_target;
            r_result    <= SNOOP_NOHIT;
            r_error     <= 1'b0;
            r_hitm_seen <= 1'b0;
            r_timer     <= '0;
        end else if (i_collect) begin
            r_pending   <= w_pending_next;
            r_result    <= w_merged;
            r_error     <= w_error_next;
            r_hitm_seen <= w_any_hitm;
            // Restart the timer on exit so a following flush wait gets its own budget.
            r_timer     <= o_done ? '0 : r_timer + TIMER_W'(1);
        end else if (i_flush_wait && !o_timeout) begin
            r_timer     <= r_timer + TIMER_W'(1);
        end
    end

endmodule

// File: rtl/bus_snoop_controller.sv
// Shared-bus transaction controller: accepts one LLC bus operation, snoops
// the other caches, waits for a HITM flush, issues the DRAM request and
// returns the combined snoop result to the initiator.
module bus_snoop_controller
    import bus_snoop_controller_pkg::*;
#(
    parameter int ADDRESS_SIZE  = 32,
    parameter int NUM_CACHES    = 4,
    parameter int SNOOP_TIMEOUT = 15,
    parameter int COUNTER_SIZE  = 32
)
(
    input  logic                   clock,
    input  logic                   reset,
    bus_snoop_controller_if.slave  bus
);
    localparam int ID_W = (NUM_CACHES > 1) ? $clog2(NUM_CACHES) : 1;

    ctrl_state_t             r_state;
    ctrl_state_t             w_next_state;
    bus_op_t                 r_op;
    logic [ADDRESS_SIZE-1:0] r_addr;
    logic [ID_W-1:0]         r_id;
    logic                    r_mem_write;
    logic                    r_flush_err;
    logic [COUNTER_SIZE-1:0] r_txn_count;
    logic                    r_out_en;

    logic                    w_accept;
    logic [NUM_CACHES-1:0]   w_target;
    logic                    w_col_done;
    logic                    w_col_timeout;
    snoop_result_t           w_col_result;
    logic                    w_col_error;

    // req_ready stays low through reset and rises on the first edge after release.
    assign w_accept = (r_state == ST_IDLE) && r_out_en && bus.req_valid;

    // Every cache except the initiator is snooped.
    always_comb begin
        w_target       = '1;
        w_target[r_id] = 1'b0;
    end

    snoop_collector #(
        .NUM_CACHES    (NUM_CACHES),
        .SNOOP_TIMEOUT (SNOOP_TIMEOUT)
    ) u_collector (
        .clock        (clock),
        .reset        (reset),
        .i_start      (r_state == ST_SNOOP),
        .i_target     (w_target),
        .i_collect    (r_state == ST_COLLECT),
        .i_flush_wait (r_state == ST_FLUSH_WAIT),
        .i_resp_valid (bus.snoop_resp_valid),
        .i_resp       (bus.snoop_resp),
        .o_done       (w_col_done),
        .o_timeout    (w_col_timeout),
        .o_result     (w_col_result),
        .o_error      (w_col_error)
    );

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = (bus.req_op == BUS_WRITE) ? ST_MEM : ST_SNOOP;
                end
            end
            ST_SNOOP: w_next_state = ST_COLLECT;
            ST_COLLECT: begin
                if (w_col_done) begin
                    if (r_op == BUS_INVALIDATE) begin
                        w_next_state = ST_DONE;
                    end else if (w_col_result == SNOOP_HITM) begin
                        w_next_state = ST_FLUSH_WAIT;
                    end else begin
                        w_next_state = ST_MEM;
                    end
                end
            end
            ST_FLUSH_WAIT: begin
                if (bus.flush_valid) begin
                    w_next_state = ST_MEM;
                end else if (w_col_timeout) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_MEM: begin
                if (bus.mem_ack) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Transaction context: latched request, memory direction, flush error, counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_op        <= BUS_READ;
            r_addr      <= '0;
            r_id        <= '0;
            r_mem_write <= 1'b0;
            r_flush_err <= 1'b0;
            r_txn_count <= '0;
            r_out_en    <= 1'b0;
        end else begin
            r_out_en <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op        <= bus.req_op;
                        r_addr      <= bus.req_addr;
                        r_id        <= bus.req_id;
                        r_mem_write <= (bus.req_op == BUS_WRITE);
                        r_flush_err <= 1'b0;
                    end
                end
                ST_COLLECT: begin
                    if (w_col_done) begin
                        r_mem_write <= 1'b0;
                    end
                end
                ST_FLUSH_WAIT: begin
                    if (bus.flush_valid) begin
                        r_mem_write <= 1'b1;
                    end else if (w_col_timeout) begin
                        r_flush_err <= 1'b1;
                    end
                end
                ST_DONE: r_txn_count <= r_txn_count + COUNTER_SIZE'(1);
                default: ;
            endcase
        end
    end

    // Outputs are decoded from registered state only.
    always_comb begin
        bus.req_ready     = r_out_en && (r_state == ST_IDLE);
        bus.snoop_valid   = '0;
        bus.snoop_op      = BUS_READ;
        bus.snoop_addr    = '0;
        bus.mem_req_valid = 1'b0;
        bus.mem_req_write = 1'b0;
        bus.mem_req_addr  = '0;
        bus.resp_valid    = 1'b0;
        bus.resp_result   = SNOOP_NOHIT;
        bus.resp_error    = 1'b0;
        case (r_state)
            ST_SNOOP: begin
                bus.snoop_valid = w_target;
                bus.snoop_op    = r_op;
                bus.snoop_addr  = r_addr;
            end
            ST_MEM: begin
                bus.mem_req_valid = 1'b1;
                bus.mem_req_write = r_mem_write;
                bus.mem_req_addr  = r_addr;
            end
            ST_DONE: begin
                bus.resp_valid = 1'b1;
                if (r_op != BUS_WRITE) begin
                    bus.resp_result = w_col_result;
                    bus.resp_error  = w_col_error | r_flush_err;
                end
            end
            default: ;
        endcase
    end

    assign bus.txn_count = r_txn_count;

endmodule

// File: tb/tb_bus_snoop_controller.sv
// Directed testbench for bus_snoop_controller: one task per scenario,
// hand-computed expectations, a passive monitor for "never happened" checks.
module tb_bus_snoop_controller;
    import bus_snoop_controller_pkg::*;

    localparam int AW = 32;
    localparam int NC = 4;
    localparam int TO = 15;
    localparam int CW = 32;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    bus_snoop_controller_if #(.ADDRESS_SIZE(AW), .NUM_CACHES(NC), .COUNTER_SIZE(CW)) bus ();

    bus_snoop_controller #(
        .ADDRESS_SIZE  (AW),
        .NUM_CACHES    (NC),
        .SNOOP_TIMEOUT (TO),
        .COUNTER_SIZE  (CW)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_mis = 0;

    // Cumulative event counters, sampled on the falling edge.
    int mon_snoop = 0;
    int mon_mem_rd = 0;
    int mon_mem_wr = 0;
    int mon_mem_unstable = 0;
    int mon_resp = 0;
    logic          prev_mem_valid = 1'b0;
    logic [AW-1:0] prev_mem_addr = '0;
    logic          prev_mem_write = 1'b0;

    always @(negedge clock) begin
        if (bus.snoop_valid != '0) mon_snoop <= mon_snoop + 1;
        if (bus.mem_req_valid && !bus.mem_req_write) mon_mem_rd <= mon_mem_rd + 1;
        if (bus.mem_req_valid && bus.mem_req_write) mon_mem_wr <= mon_mem_wr + 1;
        if (bus.resp_valid) mon_resp <= mon_resp + 1;
        if (prev_mem_valid && bus.mem_req_valid &&
            (bus.mem_req_addr !== prev_mem_addr || bus.mem_req_write !== prev_mem_write))
            mon_mem_unstable <= mon_mem_unstable + 1;
        prev_mem_valid <= bus.mem_req_valid;
        prev_mem_addr  <= bus.mem_req_addr;
        prev_mem_write <= bus.mem_req_write;
    end

    // Advance one cycle; return just after the falling edge of the next cycle.
    task automatic tick();
        @(posedge clock);
        @(negedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req_valid        = 1'b0;
        bus.req_op           = BUS_READ;
        bus.req_addr         = '0;
        bus.req_id           = '0;
        bus.snoop_resp_valid = '0;
        bus.snoop_resp       = '0;
        bus.flush_valid      = 1'b0;
        bus.mem_ack          = 1'b0;
    endtask

    // Present a request in cycle 0; returns in cycle 1 with req_valid dropped.
    task automatic issue(input string tag, input bus_op_t op, input logic [AW-1:0] addr, input logic [1:0] id);
        n_cmp++;
        if (bus.req_ready !== 1'b1) begin
            n_mis++; $display("FAIL %s_ready got %b want 1", tag, bus.req_ready);
        end
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_addr  = addr;
        bus.req_id    = id;
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        tick();
        tick();
        n_cmp++; if (bus.req_ready !== 1'b0) begin n_mis++; $display("FAIL rst_ready_in_reset got %b want 0", bus.req_ready); end
        n_cmp++; if (bus.resp_valid !== 1'b0 || bus.mem_req_valid !== 1'b0 || bus.snoop_valid !== 4'b0000) begin
            n_mis++; $display("FAIL rst_outputs got resp=%b mem=%b snoop=%b want 0/0/0000", bus.resp_valid, bus.mem_req_valid, bus.snoop_valid);
        end
        reset = 1'b1;
        tick();
        n_cmp++; if (bus.req_ready !== 1'b1) begin n_mis++; $display("FAIL rst_ready_after got %b want 1", bus.req_ready); end
        n_cmp++; if (bus.txn_count !== 32'd0) begin n_mis++; $display("FAIL rst_txn got %0d want 0", bus.txn_count); end
    endtask

    task automatic test_read();
        issue("rd", BUS_READ, 32'h0000_1000, 2'd0);
        // cycle 1
        n_cmp++; if (bus.snoop_valid !== 4'b1110) begin n_mis++; $display("FAIL rd_snoop_valid got %b want 1110", bus.snoop_valid); end
        n_cmp++; if (bus.snoop_op !== BUS_READ || bus.snoop_addr !== 32'h0000_1000) begin
            n_mis++; $display("FAIL rd_snoop_bcast got op=%0d addr=%h want op=0 addr=00001000", bus.snoop_op, bus.snoop_addr);
        end
        tick();
        // cycle 2: caches 1..3 reply NOHIT together
        bus.snoop_resp_valid = 4'b1110;
        bus.snoop_resp       = 8'h00;
        tick();
        // cycle 3
        bus.snoop_resp_valid = '0;
        n_cmp++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_write !== 1'b0 || bus.mem_req_addr !== 32'h0000_1000) begin
            n_mis++; $display("FAIL rd_mem_req got v=%b w=%b a=%h want 1/0/00001000", bus.mem_req_valid, bus.mem_req_write, bus.mem_req_addr);
        end
        bus.mem_ack = 1'b1;
        tick();
        // cycle 4
        bus.mem_ack = 1'b0;
        n_cmp++; if (bus.resp_valid !== 1'b1 || bus.resp_result !== SNOOP_NOHIT || bus.resp_error !== 1'b0) begin
            n_mis++; $display("FAIL rd_resp got v=%b r=%0d e=%b want 1/0/0", bus.resp_valid, bus.resp_result, bus.resp_error);
        end
        tick();
        // cycle 5
        n_cmp++; if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
            n_mis++; $display("FAIL rd_idle got ready=%b resp=%b want 1/0", bus.req_ready, bus.resp_valid);
        end
        n_cmp++; if (bus.txn_count !== 32'd1) begin n_mis++; $display("FAIL rd_txn got %0d want 1", bus.txn_count); end
    endtask

    task automatic test_rwim_flush();
        int rd0;
        rd0 = mon_mem_rd;
        issue("rwim", BUS_RWIM, 32'h0000_2040, 2'd2);
        n_cmp++; if (bus.snoop_valid !== 4'b1011 || bus.snoop_op !== BUS_RWIM) begin
            n_mis++; $display("FAIL rwim_snoop got %b op=%0d want 1011 op=3", bus.snoop_valid, bus.snoop_op);
        end
        tick();
        // cycle 2: cache1 HITM, caches 0 and 3 NOHIT
        bus.snoop_resp_valid = 4'b1011;
        bus.snoop_resp       = 8'h08;
        tick();
        bus.snoop_resp_valid = '0;
        // cycles 3,4: waiting for flush
        n_cmp++; if (bus.mem_req_valid !== 1'b0) begin n_mis++; $display("FAIL rwim_flush_wait_mem got %b want 0", bus.mem_req_valid); end
        tick();
        tick();
        // cycle 5: owner flushes
        bus.flush_valid = 1'b1;
        tick();
        bus.flush_valid = 1'b0;
        // cycle 6
        n_cmp++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_write !== 1'b1 || bus.mem_req_addr !== 32'h0000_2040) begin
            n_mis++; $display("FAIL rwim_mem_wr got v=%b w=%b a=%h want 1/1/00002040", bus.mem_req_valid, bus.mem_req_write, bus.mem_req_addr);
        end
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        n_cmp++; if (bus.resp_valid !== 1'b1 || bus.resp_result !== SNOOP_HITM || bus.resp_error !== 1'b0) begin
            n_mis++; $display("FAIL rwim_resp got v=%b r=%0d e=%b want 1/2/0", bus.resp_valid, bus.resp_result, bus.resp_error);
        end
        n_cmp++; if (mon_mem_rd - rd0 !== 0) begin n_mis++; $display("FAIL rwim_no_mem_read got %0d read cycles want 0", mon_mem_rd - rd0); end
        tick();
        n_cmp++; if (bus.txn_count !== 32'd2) begin n_mis++; $display("FAIL rwim_txn got %0d want 2", bus.txn_count); end
    endtask

    task automatic test_invalidate();
        int rd0, wr0;
        rd0 = mon_mem_rd;
        wr0 = mon_mem_wr;
        issue("inv", BUS_INVALIDATE, 32'h0000_3000, 2'd1);
        n_cmp++; if (bus.snoop_valid !== 4'b1101) begin n_mis++; $display("FAIL inv_snoop got %b want 1101", bus.snoop_valid); end
        tick();
        // cycle 2: c0 HIT, c2 NOHIT, c3 HIT; initiator c1 also strobes HITM and must be ignored
        bus.snoop_resp_valid = 4'b1111;
        bus.snoop_resp       = 8'h49;
        tick();
        bus.snoop_resp_valid = '0;
        n_cmp++; if (bus.resp_valid !== 1'b1 || bus.resp_result !== SNOOP_HIT || bus.resp_error !== 1'b0) begin
            n_mis++; $display("FAIL inv_resp got v=%b r=%0d e=%b want 1/1/0", bus.resp_valid, bus.resp_result, bus.resp_error);
        end
        tick();
        n_cmp++; if ((mon_mem_rd - rd0) + (mon_mem_wr - wr0) !== 0) begin
            n_mis++; $display("FAIL inv_no_mem got %0d mem cycles want 0", (mon_mem_rd - rd0) + (mon_mem_wr - wr0));
        end
        n_cmp++; if (bus.txn_count !== 32'd3) begin n_mis++; $display("FAIL inv_txn got %0d want 3", bus.txn_count); end
    endtask

    task automatic test_timeout();
        int cyc, resp0;
        resp0 = mon_resp;
        issue("to", BUS_READ, 32'h0000_4000, 2'd0);
        tick();
        // cycle 2: c1 HIT, c2 NOHIT, c3 never answers
        bus.snoop_resp_valid = 4'b0110;
        bus.snoop_resp       = 8'h04;
        tick();
        bus.snoop_resp_valid = '0;
        cyc = 3;
        while (bus.mem_req_valid !== 1'b1 && cyc < 60) begin
            tick();
            cyc++;
        end
        // COLLECT spans cycles 2..17 (timer 0..15), so MEM starts in cycle 18.
        n_cmp++; if (cyc !== 18) begin n_mis++; $display("FAIL to_mem_cycle got %0d want 18", cyc); end
        n_cmp++; if (mon_resp - resp0 !== 0) begin n_mis++; $display("FAIL to_early_resp got %0d want 0", mon_resp - resp0); end
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        n_cmp++; if (bus.resp_valid !== 1'b1 || bus.resp_result !== SNOOP_HIT || bus.resp_error !== 1'b1) begin
            n_mis++; $display("FAIL to_resp got v=%b r=%0d e=%b want 1/1/1", bus.resp_valid, bus.resp_result, bus.resp_error);
        end
        tick();
    endtask

    task automatic test_multi_hitm();
        issue("mh", BUS_READ, 32'h0000_5000, 2'd0);
        tick();
        // cycle 2: c1 and c2 both HITM, c3 NOHIT
        bus.snoop_resp_valid = 4'b1110;
        bus.snoop_resp       = 8'h28;
        tick();
        bus.snoop_resp_valid = '0;
        bus.flush_valid      = 1'b1;
        tick();
        bus.flush_valid = 1'b0;
        n_cmp++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_write !== 1'b1) begin
            n_mis++; $display("FAIL mh_mem_wr got v=%b w=%b want 1/1", bus.mem_req_valid, bus.mem_req_write);
        end
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        n_cmp++; if (bus.resp_valid !== 1'b1 || bus.resp_result !== SNOOP_HITM || bus.resp_error !== 1'b1) begin
            n_mis++; $display("FAIL mh_resp got v=%b r=%0d e=%b want 1/2/1", bus.resp_valid, bus.resp_result, bus.resp_error);
        end
        tick();
        n_cmp++; if (bus.txn_count !== 32'd5) begin n_mis++; $display("FAIL mh_txn got %0d want 5", bus.txn_count); end
    endtask

    task automatic test_write_delayed_ack();
        int sn0, wr0, un0;
        sn0 = mon_snoop;
        wr0 = mon_mem_wr;
        un0 = mon_mem_unstable;
        issue("wr", BUS_WRITE, 32'hDEAD_BE00, 2'd2);
        for (int c = 1; c <= 6; c++) begin
            n_cmp++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_write !== 1'b1 || bus.mem_req_addr !== 32'hDEAD_BE00) begin
                n_mis++; $display("FAIL wr_mem_cycle%0d got v=%b w=%b a=%h want 1/1/deadbe00", c, bus.mem_req_valid, bus.mem_req_write, bus.mem_req_addr);
            end
            if (c == 6) bus.mem_ack = 1'b1;
            tick();
        end
        bus.mem_ack = 1'b0;
        n_cmp++; if (bus.resp_valid !== 1'b1 || bus.resp_result !== SNOOP_NOHIT || bus.resp_error !== 1'b0) begin
            n_mis++; $display("FAIL wr_resp got v=%b r=%0d e=%b want 1/0/0", bus.resp_valid, bus.resp_result, bus.resp_error);
        end
        n_cmp++; if (mon_snoop - sn0 !== 0) begin n_mis++; $display("FAIL wr_no_snoop got %0d want 0", mon_snoop - sn0); end
        n_cmp++; if (mon_mem_wr - wr0 !== 6 || mon_mem_unstable - un0 !== 0) begin
            n_mis++; $display("FAIL wr_mem_hold got cycles=%0d unstable=%0d want 6/0", mon_mem_wr - wr0, mon_mem_unstable - un0);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        // WRITE with ack in its first MEM cycle: resp_valid in cycle 2.
        issue("b2b", BUS_WRITE, 32'h0000_0040, 2'd0);
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        n_cmp++; if (bus.resp_valid !== 1'b1 || bus.resp_result !== SNOOP_NOHIT) begin
            n_mis++; $display("FAIL b2b_resp got v=%b r=%0d want 1/0", bus.resp_valid, bus.resp_result);
        end
        tick();
        // Stray inputs while idle must be ignored.
        bus.mem_ack          = 1'b1;
        bus.flush_valid      = 1'b1;
        bus.snoop_resp_valid = 4'b1111;
        bus.snoop_resp       = 8'hAA;
        tick();
        idle_inputs();
        n_cmp++; if (bus.req_ready !== 1'b1 || bus.mem_req_valid !== 1'b0 || bus.resp_valid !== 1'b0) begin
            n_mis++; $display("FAIL idle_ignore got ready=%b mem=%b resp=%b want 1/0/0", bus.req_ready, bus.mem_req_valid, bus.resp_valid);
        end
        n_cmp++; if (bus.txn_count !== 32'd7) begin n_mis++; $display("FAIL b2b_txn got %0d want 7", bus.txn_count); end
    endtask

    task automatic test_reset_mid_txn();
        int resp0;
        issue("rm", BUS_READ, 32'h0000_6000, 2'd0);
        tick();
        bus.snoop_resp_valid = 4'b1110;
        bus.snoop_resp       = 8'h00;
        tick();
        bus.snoop_resp_valid = '0;
        n_cmp++; if (bus.mem_req_valid !== 1'b1) begin n_mis++; $display("FAIL rm_in_mem got %b want 1", bus.mem_req_valid); end
        resp0 = mon_resp;
        reset = 1'b0;
        #1;
        n_cmp++; if (bus.mem_req_valid !== 1'b0 || bus.req_ready !== 1'b0 || bus.snoop_valid !== 4'b0000 || bus.resp_valid !== 1'b0) begin
            n_mis++; $display("FAIL rm_outputs got mem=%b ready=%b snoop=%b resp=%b want 0/0/0000/0", bus.mem_req_valid, bus.req_ready, bus.snoop_valid, bus.resp_valid);
        end
        n_cmp++; if (bus.txn_count !== 32'd0) begin n_mis++; $display("FAIL rm_txn_in_reset got %0d want 0", bus.txn_count); end
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        tick();
        n_cmp++; if (bus.req_ready !== 1'b1 || bus.txn_count !== 32'd0) begin
            n_mis++; $display("FAIL rm_after got ready=%b txn=%0d want 1/0", bus.req_ready, bus.txn_count);
        end
        n_cmp++; if (mon_resp - resp0 !== 0) begin n_mis++; $display("FAIL rm_no_resp got %0d pulses want 0", mon_resp - resp0); end
    endtask

    initial begin
        test_reset();
        test_read();
        test_rwim_flush();
        test_invalidate();
        test_timeout();
        test_multi_hitm();
        test_write_delayed_ack();
        test_back_to_back();
        test_reset_mid_txn();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bus_snoop_controller.md
# bus_snoop_controller

Shared-bus transaction controller: the responder/arbiter end of the LLC bus protocol. It accepts one bus operation at a time from an initiating LLC (READ, WRITE, INVALIDATE, RWIM), broadcasts it as a snoop to every other cache, and collects and combines their snoop results (NOHIT/HIT/HITM). For HITM it waits for the owner's flush; it drives the DRAM request and returns the combined snoop result to the initiator. It sits between the per-core LLC instances and the memory controller.

## Interface
Parameters:
- ADDRESS_SIZE, 32, bus address width
- NUM_CACHES, 4, number of attached LLCs (requesters and snoopers)
- SNOOP_TIMEOUT, 15, max cycles waiting for snoop responses or flush
- COUNTER_SIZE, 32, transaction counter width

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low
- req_valid  in  1  initiator presents operation
- req_ready  out  1  controller idle, accepts request
- req_op  in  2  bus_op_t: READ=0, WRITE=1, INVALIDATE=2, RWIM=3
- req_addr  in  ADDRESS_SIZE  line address
- req_id  in  $clog2(NUM_CACHES)  initiator index, excluded from snoop
- snoop_valid  out  NUM_CACHES  one-hot-per-cache snoop strobe
- snoop_op  out  2  broadcast operation
- snoop_addr  out  ADDRESS_SIZE  broadcast address
- snoop_resp_valid  in  NUM_CACHES  per-cache response strobe
- snoop_resp  in  2*NUM_CACHES  per-cache snoop_result_t (NOHIT=0, HIT=1, HITM=2)
- flush_valid  in  1  HITM owner has written back the line
- mem_req_valid  out  1  DRAM request, held until ack
- mem_req_write  out  1  1 = write, 0 = read
- mem_req_addr  out  ADDRESS_SIZE  DRAM address
- mem_ack  in  1  DRAM accepts request
- resp_valid  out  1  one-cycle completion pulse to initiator
- resp_result  out  2  combined snoop result
- resp_error  out  1  timeout or multiple-HITM protocol error
- txn_count  out  COUNTER_SIZE  completed transactions

## Operation
- States: IDLE, SNOOP, COLLECT, FLUSH_WAIT, MEM, DONE.
- IDLE: req_ready=1. On req_valid, latch op/addr/id. WRITE goes to MEM (writeback, no snoop). Others go to SNOOP.
- SNOOP: snoop_valid=1 for every cache except req_id, for one cycle. Load pending mask with the same bits. Clear the timer.
- COLLECT: a snoop_resp_valid bit clears its pending bit and merges its result. Priority is HITM > HIT > NOHIT.
  - Strobes from non-pending caches are ignored.
  - A response arriving in the same cycle the mask empties counts.
  - Two or more HITM set the error flag.
- When the mask empties, or at timeout, exit COLLECT. On timeout, missing responders count as NOHIT and the error flag is set.
  - INVALIDATE goes to DONE.
  - HITM goes to FLUSH_WAIT.
  - Otherwise (READ or RWIM) goes to MEM read.
- FLUSH_WAIT: wait for flush_valid, then go to MEM write of the latched address. If SNOOP_TIMEOUT expires first, set the error flag and go to DONE.
- MEM: mem_req_valid=1 with stable addr and write bit until mem_ack, including an ack in the first cycle. Then go to DONE.
- DONE: resp_valid=1, resp_result=combined (NOHIT for WRITE), resp_error=flag. txn_count increments. Next state is IDLE.
- Reset values: state IDLE, req_ready=1 after reset release, all other outputs 0, txn_count 0, mask/flag/timer cleared.
- Reset asserted mid-transaction aborts it. No response pulse is produced.
- Inputs received in IDLE (snoop_resp_valid, flush_valid, mem_ack) are ignored.
- txn_count wraps modulo 2^COUNTER_SIZE.

## Timing
- Request accepted at edge ending cycle 0.
- Non-WRITE request: snoop_valid in cycle 1; COLLECT from cycle 2.
- READ, all responses in cycle 2, mem_ack in cycle 3: resp_valid in cycle 4; req_ready high again in cycle 5.
- WRITE with immediate ack: mem_req_valid in cycle 1, resp_valid in cycle 2.
- Timer counts cycles in COLLECT/FLUSH_WAIT. Timeout fires when the timer reaches SNOOP_TIMEOUT with work still outstanding.
- No combinational path from any input to req_ready or snoop_valid.

## Structure
- Shared package holds:
  - bus_op_t and snoop_result_t, reusing the existing bus-operation/snoop encodings;
  - ctrl_state_t;
  - function snoop_merge(a,b), returning the higher-priority result.
- Sub-module snoop_collector holds the pending mask, merged result, multi-HITM detect and timer. It takes start/target mask and outputs done/result/error.

## Test plan
- READ 0x0000_1000 from cache 0; caches 1–3 reply NOHIT in cycle 2; mem_ack immediate -> mem read 0x1000, resp_valid cycle 4, resp_result=NOHIT, error=0, txn_count=1.
- RWIM from cache 2; cache 1 HITM, others NOHIT; flush_valid 3 cycles later -> snoop_valid=4'b1011, mem write 0x…, resp_result=HITM, no mem read.
- INVALIDATE from cache 1, responses HIT/NOHIT/HIT -> no mem_req_valid, resp_result=HIT.
- READ with cache 3 silent -> resp_valid after SNOOP_TIMEOUT, resp_error=1, result from others; caches 1 and 2 both HITM in another READ -> resp_error=1.
- WRITE 0xDEAD_BE00 with mem_ack delayed 5 cycles -> mem_req_valid held stable 6 cycles, resp_result=NOHIT, no snoop_valid.
- Reset low during MEM -> all outputs 0 immediately, no resp_valid; after release req_ready=1 and txn_count=0.
